ssd_scan_mux: RTL

- Time-multiplexing scanner that sits directly upstream of the single-digit seven-segment decoder/driver on the Nexys A7-100T.
- Holds a 32-bit hex value (8 nibbles), a per-digit enable mask and a per-digit decimal-point mask.
- Cycles through the 8 digits, presenting one nibble and its dp to the decoder while driving the matching active-low anode.
- Inserts an all-anodes-off blanking interval at every digit change to suppress ghosting. New values are double-buffered so a frame never shows a mix of old and new values.

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_slot_prescaler.sv | 35 +++
 rtl/ssd_scan_mux.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan path: digit count, anode idle pattern,
// scanner slot states and the segment encodings used by the downstream decoder.
package ssd_pkg;

  localparam int unsigned N_DIGITS = 8;

  localparam logic [N_DIGITS-1:0] ANODE_ALL_OFF = 8'hFF;

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } ssd_state_e;

  // Active-low segments, bit order {g, f, e, d, c, b, a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_slot_prescaler.sv
// Free-running slot counter: counts 0..DIV-1 and flags the last cycle of each slot.
module ssd_slot_prescaler #(
  parameter int unsigned DIV   = 8,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             slot_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (slot_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign slot_end_o = slot_end;

endmodule

// File: rtl/ssd_scan_mux.sv
// Eight-digit time-multiplexed scanner with per-slot anode blanking and frame-synchronous
// double buffering of the displayed value and masks.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned SLOT_HZ      = 8000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                  ssd_scan_mux_port_clk,
  input  logic                  ssd_scan_mux_port_rst,
  input  logic [31:0]           ssd_scan_mux_port_value,
  input  logic [N_DIGITS-1:0]   ssd_scan_mux_port_en_mask,
  input  logic [N_DIGITS-1:0]   ssd_scan_mux_port_dp_mask,
  input  logic                  ssd_scan_mux_port_load,
  output logic [3:0]            ssd_scan_mux_port_nibble,
  output logic                  ssd_scan_mux_port_dp,
  output logic [N_DIGITS-1:0]   ssd_scan_mux_port_an,
  output logic [2:0]            ssd_scan_mux_port_idx,
  output logic                  ssd_scan_mux_port_frame_done
);

  localparam int unsigned DIV   = CLK_HZ / SLOT_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             slot_end;
  logic             frame_end;

  ssd_slot_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk_i      (ssd_scan_mux_port_clk),
    .rst_i      (ssd_scan_mux_port_rst),
    .cnt_o      (cnt),
    .slot_end_o (slot_end)
  );

  ssd_state_e          state_q, state_d;
  logic [2:0]          idx_q, idx_d;

  logic [31:0]         val_pend_q, val_pend_d;
  logic [N_DIGITS-1:0] en_pend_q, en_pend_d;
  logic [N_DIGITS-1:0] dp_pend_q, dp_pend_d;
  logic                pend_q, pend_d;

  logic [31:0]         val_act_q, val_act_d;
  logic [N_DIGITS-1:0] en_act_q, en_act_d;
  logic [N_DIGITS-1:0] dp_act_q, dp_act_d;

  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          nibble_q, nibble_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  assign frame_end = slot_end && (idx_q == 3'd7);
  assign cnt_nxt   = slot_end ? '0 : cnt + 1'b1;

  // Slot FSM: blank at the start of every slot, then show until the slot ends.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: begin
        if (!slot_end && ((32'(cnt) + 32'd1) >= BLANK_CYCLES)) begin
          state_d = StShow;
        end
      end
      StShow: begin
        if (slot_end && (BLANK_CYCLES != 0)) begin
          state_d = StBlank;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = idx_q + 3'd1;
    end
  end

  // Active copy only changes on the frame boundary; a load on that same cycle bypasses pending.
  always_comb begin
    val_pend_d = val_pend_q;
    en_pend_d  = en_pend_q;
    dp_pend_d  = dp_pend_q;
    pend_d     = pend_q;
    val_act_d  = val_act_q;
    en_act_d   = en_act_q;
    dp_act_d   = dp_act_q;

    if (ssd_scan_mux_port_load) begin
      val_pend_d = ssd_scan_mux_port_value;
      en_pend_d  = ssd_scan_mux_port_en_mask;
      dp_pend_d  = ssd_scan_mux_port_dp_mask;
    end

    if (frame_end) begin
      pend_d = 1'b0;
      if (ssd_scan_mux_port_load) begin
        val_act_d = ssd_scan_mux_port_value;
        en_act_d  = ssd_scan_mux_port_en_mask;
        dp_act_d  = ssd_scan_mux_port_dp_mask;
      end else if (pend_q) begin
        val_act_d = val_pend_q;
        en_act_d  = en_pend_q;
        dp_act_d  = dp_pend_q;
      end
    end else if (ssd_scan_mux_port_load) begin
      pend_d = 1'b1;
    end
  end

  // Outputs are registered from next-state so they line up with the slot they describe.
  always_comb begin
    an_d = ANODE_ALL_OFF;
    if (state_d == StShow) begin
      an_d[idx_d] = ~en_act_d[idx_d];
    end
    nibble_d     = val_act_d[{idx_d, 2'b00} +: 4];
    dp_d         = ~dp_act_d[idx_d];
    frame_done_d = (idx_d == 3'd7) && (cnt_nxt == CNT_W'(DIV - 1));
  end

  always_ff @(posedge ssd_scan_mux_port_clk) begin
    if (ssd_scan_mux_port_rst) begin
      state_q      <= StBlank;
      idx_q        <= 3'd0;
      val_pend_q   <= '0;
      en_pend_q    <= '0;
      dp_pend_q    <= '0;
      pend_q       <= 1'b0;
      val_act_q    <= '0;
      en_act_q     <= '0;
      dp_act_q     <= '0;
      an_q         <= ANODE_ALL_OFF;
      nibble_q     <= 4'h0;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      val_pend_q   <= val_pend_d;
      en_pend_q    <= en_pend_d;
      dp_pend_q    <= dp_pend_d;
      pend_q       <= pend_d;
      val_act_q    <= val_act_d;
      en_act_q     <= en_act_d;
      dp_act_q     <= dp_act_d;
      an_q         <= an_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ssd_scan_mux_port_an         = an_q;
  assign ssd_scan_mux_port_nibble     = nibble_q;
  assign ssd_scan_mux_port_dp         = dp_q;
  assign ssd_scan_mux_port_idx        = idx_q;
  assign ssd_scan_mux_port_frame_done = frame_done_q;

endmodule
